pool1d: RTL and testbench

- Multi-channel 1D pooling stage. It is the parametrised successor to the single-channel sum accumulator.
- Reduces every POOL_SIZE consecutive input beats to one output beat, per channel, in SUM, MAX or AVG mode.
- Supports signed or unsigned data and early window termination via a last flag.
- Sits between a conv/activation stage and the next layer on valid/ready streams. Sustains 1 beat/cycle with no reset bubble between windows.

---
 rtl/cnn1d_pkg.sv | 23 ++
 rtl/pool1d_lane.sv | 72 +++++++
 rtl/pool1d.sv | 87 ++++++++
 tb/tb_pool1d.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn1d_pkg.sv
// Shared types and helpers for the 1D CNN datapath blocks.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package cnn1d_pkg;

  // Reduction applied across one pooling window.
  typedef enum logic [1:0] {
    POOL_SUM = 2'd0,
    POOL_MAX = 2'd1,
    POOL_AVG = 2'd2
  } pool_mode_t;

  // Ceiling log2, used to size window counters and sum growth; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pool1d_lane.sv
// One channel of pool1d: running accumulator, combine with the current sample, output mapping.
// Latency: result is combinational (acc op sample); the parent registers it when a window closes.
// Backpressure: none locally; acc only moves on beats the parent has accepted.
module pool1d_lane
  import cnn1d_pkg::*;
#(
  parameter int         DATA_WIDTH = 12,
  parameter int         POOL_SIZE  = 10,
  parameter pool_mode_t MODE       = POOL_SUM,
  parameter bit         SIGNED     = 1'b0,
  localparam int COUNTER_WIDTH = clog2(POOL_SIZE),
  localparam int ACC_WIDTH     = DATA_WIDTH + COUNTER_WIDTH,
  localparam int OUT_WIDTH     = (MODE == POOL_SUM) ? ACC_WIDTH : DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_fire,
  input  logic                  win_close,
  input  logic [DATA_WIDTH-1:0] sample,
  output logic [OUT_WIDTH-1:0]  result
);

  if (MODE == POOL_MAX) begin : g_max
    // Identity is the smallest representable value so the first sample always wins.
    localparam logic [DATA_WIDTH-1:0] IDENT =
      SIGNED ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {DATA_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] combined;
    logic                  take;

    assign take     = SIGNED ? ($signed(sample) > $signed(acc_q)) : (sample > acc_q);
    assign combined = take ? sample : acc_q;
    assign result   = combined;

    // Running max; reload identity on window close so the next window starts without a bubble.
    always_ff @(posedge clk) begin
      if (rst) begin
        acc_q <= IDENT;
      end else if (in_fire) begin
        acc_q <= win_close ? IDENT : combined;
      end
    end
  end else begin : g_sum
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] ext;
    logic [ACC_WIDTH-1:0] combined;

    // Extra COUNTER_WIDTH bits of headroom cover POOL_SIZE full-scale samples.
    assign ext = SIGNED ? {{COUNTER_WIDTH{sample[DATA_WIDTH-1]}}, sample}
                        : {{COUNTER_WIDTH{1'b0}}, sample};
    assign combined = acc_q + ext;

    // Running sum; cleared on window close so the closing beat's total goes only to the output.
    always_ff @(posedge clk) begin
      if (rst) begin
        acc_q <= '0;
      end else if (in_fire) begin
        acc_q <= win_close ? '0 : combined;
      end
    end

    if (MODE == POOL_AVG) begin : g_avg
      // Divide by the full window size even for short windows; POOL_SIZE is a power of two here.
      assign result = SIGNED ? DATA_WIDTH'($signed(combined) >>> COUNTER_WIDTH)
                             : DATA_WIDTH'(combined >> COUNTER_WIDTH);
    end else begin : g_full
      assign result = combined;
    end
  end

endmodule

// File: rtl/pool1d.sv
// Multi-channel 1D pooling: reduces POOL_SIZE beats (fewer when pool_last_in) per channel to one result.
// Latency: 1 cycle from the window-closing input handshake to pool_valid_out.
// Backpressure: a held output stalls input (ready_in = !valid_out || ready_out); acc/count freeze.
module pool1d
  import cnn1d_pkg::*;
#(
  parameter int         DATA_WIDTH   = 12,
  parameter int         NUM_CHANNELS = 1,
  parameter int         POOL_SIZE    = 10,
  parameter pool_mode_t MODE         = POOL_SUM,
  parameter bit         SIGNED       = 1'b0,
  localparam int COUNTER_WIDTH = clog2(POOL_SIZE),
  localparam int OUT_WIDTH     = (MODE == POOL_SUM) ? DATA_WIDTH + COUNTER_WIDTH : DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic                              pool_ready_in,
  input  logic                              pool_valid_in,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] pool_data_in,
  input  logic                              pool_last_in,
  input  logic                              pool_ready_out,
  output logic                              pool_valid_out,
  output logic [NUM_CHANNELS*OUT_WIDTH-1:0]  pool_data_out,
  output logic                              pool_last_out
);

  if (POOL_SIZE < 2) begin : g_bad_size
    $error("pool1d: POOL_SIZE must be at least 2");
  end

  if (MODE == POOL_AVG && (POOL_SIZE & (POOL_SIZE - 1)) != 0) begin : g_bad_avg
    $error("pool1d: POOL_AVG needs a power-of-two POOL_SIZE");
  end

  localparam logic [COUNTER_WIDTH-1:0] LAST_COUNT = COUNTER_WIDTH'(POOL_SIZE - 1);

  logic [COUNTER_WIDTH-1:0]          count_q;
  logic                              in_fire;
  logic                              win_close;
  logic [NUM_CHANNELS*OUT_WIDTH-1:0] lane_result;

  // A free output slot, or one being drained this cycle, lets a new beat in.
  assign pool_ready_in = !pool_valid_out || pool_ready_out;
  assign in_fire       = pool_valid_in && pool_ready_in;
  assign win_close     = in_fire && ((count_q == LAST_COUNT) || pool_last_in);

  // Beat position within the current window; never counts past POOL_SIZE-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (in_fire) begin
      count_q <= win_close ? '0 : count_q + COUNTER_WIDTH'(1);
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
    pool1d_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .POOL_SIZE  (POOL_SIZE),
      .MODE       (MODE),
      .SIGNED     (SIGNED)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .in_fire   (in_fire),
      .win_close (win_close),
      .sample    (pool_data_in[c*DATA_WIDTH +: DATA_WIDTH]),
      .result    (lane_result[c*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  // Output slot: load on close (even while draining the previous result), clear on drain only.
  always_ff @(posedge clk) begin
    if (rst) begin
      pool_valid_out <= 1'b0;
      pool_data_out  <= '0;
      pool_last_out  <= 1'b0;
    end else if (win_close) begin
      pool_valid_out <= 1'b1;
      pool_data_out  <= lane_result;
      pool_last_out  <= pool_last_in;
    end else if (pool_ready_out) begin
      pool_valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool1d.sv
module tb_pool1d;
  import cnn1d_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  // SUM, 1 channel, DW=12, POOL_SIZE=10, unsigned
  logic        sum_rdy, sum_vin, sum_lin, sum_rout, sum_vout, sum_lout;
  logic [11:0] sum_din;
  logic [15:0] sum_dout;

  pool1d #(.DATA_WIDTH(12), .NUM_CHANNELS(1), .POOL_SIZE(10), .MODE(POOL_SUM), .SIGNED(1'b0)) u_sum (
    .clk(clk), .rst(rst), .pool_ready_in(sum_rdy), .pool_valid_in(sum_vin), .pool_data_in(sum_din),
    .pool_last_in(sum_lin), .pool_ready_out(sum_rout), .pool_valid_out(sum_vout),
    .pool_data_out(sum_dout), .pool_last_out(sum_lout));

  // Small configs share valid/last/ready_out
  logic        s_vin, s_lin, s_rout;
  logic [15:0] max_din, max_dout;
  logic        max_rdy, max_vout, max_lout;
  logic [7:0]  avs_din, avs_dout, avu_din, avu_dout;
  logic        avs_rdy, avs_vout, avs_lout, avu_rdy, avu_vout, avu_lout;

  pool1d #(.DATA_WIDTH(8), .NUM_CHANNELS(2), .POOL_SIZE(4), .MODE(POOL_MAX), .SIGNED(1'b1)) u_max (
    .clk(clk), .rst(rst), .pool_ready_in(max_rdy), .pool_valid_in(s_vin), .pool_data_in(max_din),
    .pool_last_in(s_lin), .pool_ready_out(s_rout), .pool_valid_out(max_vout),
    .pool_data_out(max_dout), .pool_last_out(max_lout));

  pool1d #(.DATA_WIDTH(8), .NUM_CHANNELS(1), .POOL_SIZE(4), .MODE(POOL_AVG), .SIGNED(1'b1)) u_avs (
    .clk(clk), .rst(rst), .pool_ready_in(avs_rdy), .pool_valid_in(s_vin), .pool_data_in(avs_din),
    .pool_last_in(s_lin), .pool_ready_out(s_rout), .pool_valid_out(avs_vout),
    .pool_data_out(avs_dout), .pool_last_out(avs_lout));

  pool1d #(.DATA_WIDTH(8), .NUM_CHANNELS(1), .POOL_SIZE(4), .MODE(POOL_AVG), .SIGNED(1'b0)) u_avu (
    .clk(clk), .rst(rst), .pool_ready_in(avu_rdy), .pool_valid_in(s_vin), .pool_data_in(avu_din),
    .pool_last_in(s_lin), .pool_ready_out(s_rout), .pool_valid_out(avu_vout),
    .pool_data_out(avu_dout), .pool_last_out(avu_lout));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model + scoreboard for the SUM instance, evaluated mid-cycle
  typedef struct {
    logic [15:0] d;
    logic        l;
  } exp_t;
  exp_t        sb[$];
  logic        m_pend = 1'b0;
  logic [15:0] m_acc = '0;
  int          m_cnt = 0;

  initial begin : model
    exp_t        e;
    logic        fire, cls;
    logic [15:0] nsum;
    forever begin
      @(negedge clk);
      chk("sum_valid_out", 32'(sum_vout), 32'(m_pend));
      chk("sum_ready_in", 32'(sum_rdy), 32'(!m_pend || sum_rout));
      if (rst) begin
        m_pend = 1'b0;
        m_acc  = '0;
        m_cnt  = 0;
        sb.delete();
      end else begin
        if (m_pend && sum_rout) begin
          if (sb.size() == 0) begin
            chk("sb_pop_nonempty", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            chk("sum_data", 32'(sum_dout), 32'(e.d));
            chk("sum_last", 32'(sum_lout), 32'(e.l));
          end
        end
        fire = sum_vin && (!m_pend || sum_rout);
        cls  = 1'b0;
        if (fire) begin
          nsum = m_acc + {4'b0, sum_din};
          cls  = (m_cnt == 9) || sum_lin;
          if (cls) begin
            e.d = nsum;
            e.l = sum_lin;
            sb.push_back(e);
            m_acc = '0;
            m_cnt = 0;
          end else begin
            m_acc = nsum;
            m_cnt++;
          end
        end
        m_pend = cls || (m_pend && !sum_rout);
      end
    end
  end

  task automatic sum_beat(input logic [11:0] d, input logic last);
    @(posedge clk); #1;
    sum_vin = 1'b1; sum_din = d; sum_lin = last;
  endtask

  task automatic sum_idle();
    @(posedge clk); #1;
    sum_vin = 1'b0; sum_lin = 1'b0;
  endtask

  task automatic sum_expect(input string name, input logic [15:0] d, input logic last);
    @(negedge clk);
    chk({name, "_valid"}, 32'(sum_vout), 32'd1);
    chk({name, "_data"}, 32'(sum_dout), 32'(d));
    chk({name, "_last"}, 32'(sum_lout), 32'(last));
  endtask

  typedef struct {
    int         n;
    logic       early;
    logic [7:0] m0[4];
    logic [7:0] m1[4];
    logic [7:0] av_s[4];
    logic [7:0] av_u[4];
    logic [7:0] e_m0, e_m1, e_s, e_u;
  } vec_t;
  vec_t tbl[4];

  initial begin
    tbl[0].n = 4; tbl[0].early = 1'b0;
    tbl[0].m0 = '{8'hFB, 8'hFE, 8'hF7, 8'hF9}; tbl[0].m1 = '{8'h03, 8'h64, 8'h80, 8'h00};
    tbl[0].av_s = '{8'hFD, 8'hFD, 8'hFD, 8'hFE}; tbl[0].av_u = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[0].e_m0 = 8'hFE; tbl[0].e_m1 = 8'h64; tbl[0].e_s = 8'hFD; tbl[0].e_u = 8'hFF;
    tbl[1].n = 4; tbl[1].early = 1'b0;
    tbl[1].m0 = '{8'h80, 8'h80, 8'h80, 8'h80}; tbl[1].m1 = '{8'h7F, 8'h01, 8'h02, 8'h03};
    tbl[1].av_s = '{8'h80, 8'h80, 8'h80, 8'h80}; tbl[1].av_u = '{8'h00, 8'h01, 8'h02, 8'h03};
    tbl[1].e_m0 = 8'h80; tbl[1].e_m1 = 8'h7F; tbl[1].e_s = 8'h80; tbl[1].e_u = 8'h01;
    tbl[2].n = 2; tbl[2].early = 1'b1;
    tbl[2].m0 = '{8'h07, 8'hFD, 8'h00, 8'h00}; tbl[2].m1 = '{8'h9C, 8'hCE, 8'h00, 8'h00};
    tbl[2].av_s = '{8'h08, 8'h04, 8'h00, 8'h00}; tbl[2].av_u = '{8'hC8, 8'h64, 8'h00, 8'h00};
    tbl[2].e_m0 = 8'h07; tbl[2].e_m1 = 8'hCE; tbl[2].e_s = 8'h03; tbl[2].e_u = 8'h4B;
    tbl[3].n = 4; tbl[3].early = 1'b0;
    tbl[3].m0 = '{8'h00, 8'hFF, 8'h05, 8'h04}; tbl[3].m1 = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[3].av_s = '{8'h01, 8'h02, 8'h03, 8'h05}; tbl[3].av_u = '{8'h01, 8'h01, 8'h01, 8'h00};
    tbl[3].e_m0 = 8'h05; tbl[3].e_m1 = 8'hFF; tbl[3].e_s = 8'h02; tbl[3].e_u = 8'h00;

    rst = 1'b1; sum_vin = 1'b0; sum_lin = 1'b0; sum_din = '0; sum_rout = 1'b1;
    s_vin = 1'b0; s_lin = 1'b0; s_rout = 1'b1; max_din = '0; avs_din = '0; avu_din = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_sum_valid", 32'(sum_vout), 32'd0);
    chk("rst_sum_data", 32'(sum_dout), 32'd0);
    chk("rst_sum_last", 32'(sum_lout), 32'd0);
    chk("rst_max_valid", 32'(max_vout), 32'd0);
    chk("rst_max_data", 32'(max_dout), 32'd0);
    chk("rst_ready_in", 32'(sum_rdy), 32'd1);

    // 1..10 then 11..20 back to back
    for (int v = 1; v <= 20; v++) begin
      sum_beat(12'(v), 1'b0);
      if (v == 10) begin
        @(negedge clk);
        chk("win1_not_early", 32'(sum_vout), 32'd0);
      end
      if (v == 11) begin
        sum_expect("win1", 16'd55, 1'b0);
        chk("win1_no_bubble_ready", 32'(sum_rdy), 32'd1);
      end
    end
    sum_idle();
    sum_expect("win2", 16'd155, 1'b0);

    // early termination, then a full window of ones
    sum_beat(12'd5, 1'b0); sum_beat(12'd6, 1'b0); sum_beat(12'd7, 1'b1);
    sum_idle();
    sum_expect("early", 16'd18, 1'b1);
    for (int i = 0; i < 10; i++) sum_beat(12'd1, 1'b0);
    sum_idle();
    sum_expect("after_early", 16'd10, 1'b0);

    // last on the first beat of a window
    sum_beat(12'd9, 1'b1);
    sum_idle();
    sum_expect("single", 16'd9, 1'b1);

    // 5-cycle output stall with input offered
    for (int v = 1; v <= 10; v++) sum_beat(12'(v), 1'b0);
    @(posedge clk); #1;
    sum_rout = 1'b0; sum_vin = 1'b1; sum_din = 12'd7; sum_lin = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_ready_in", 32'(sum_rdy), 32'd0);
      chk("stall_valid", 32'(sum_vout), 32'd1);
      chk("stall_data", 32'(sum_dout), 32'd55);
    end
    @(posedge clk); #1;
    sum_rout = 1'b1; sum_vin = 1'b0;
    for (int i = 0; i < 10; i++) sum_beat(12'd3, 1'b0);
    sum_idle();
    sum_expect("after_stall", 16'd30, 1'b0);

    // reset in the middle of a window
    for (int i = 0; i < 6; i++) sum_beat(12'd9, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; sum_vin = 1'b1; sum_din = 12'd50;
    @(posedge clk);
    @(negedge clk);
    chk("in_rst_valid", 32'(sum_vout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; sum_vin = 1'b0;
    for (int i = 0; i < 10; i++) sum_beat(12'd2, 1'b0);
    sum_idle();
    sum_expect("post_rst", 16'd20, 1'b0);

    // random valid/ready traffic, checked by the model
    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #1;
      sum_vin  = ($urandom_range(0, 9) < 7);
      sum_rout = ($urandom_range(0, 9) < 6);
      sum_din  = 12'($urandom_range(0, 4095));
      sum_lin  = ($urandom_range(0, 19) == 0);
    end
    @(posedge clk); #1;
    sum_vin = 1'b0; sum_lin = 1'b0; sum_rout = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // MAX / AVG table
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < tbl[r].n; b++) begin
        @(posedge clk); #1;
        s_vin   = 1'b1;
        s_lin   = tbl[r].early && (b == tbl[r].n - 1);
        max_din = {tbl[r].m1[b], tbl[r].m0[b]};
        avs_din = tbl[r].av_s[b];
        avu_din = tbl[r].av_u[b];
      end
      @(negedge clk);
      chk("tbl_max_not_early", 32'(max_vout), 32'd0);
      @(posedge clk); #1;
      s_vin = 1'b0; s_lin = 1'b0;
      @(negedge clk);
      chk("tbl_max_valid", 32'(max_vout), 32'd1);
      chk("tbl_max_ch0", 32'(max_dout[7:0]), 32'(tbl[r].e_m0));
      chk("tbl_max_ch1", 32'(max_dout[15:8]), 32'(tbl[r].e_m1));
      chk("tbl_max_last", 32'(max_lout), 32'(tbl[r].early));
      chk("tbl_avs_valid", 32'(avs_vout), 32'd1);
      chk("tbl_avs_data", 32'(avs_dout), 32'(tbl[r].e_s));
      chk("tbl_avs_last", 32'(avs_lout), 32'(tbl[r].early));
      chk("tbl_avu_valid", 32'(avu_vout), 32'd1);
      chk("tbl_avu_data", 32'(avu_dout), 32'(tbl[r].e_u));
      chk("tbl_avu_rdy", 32'(avu_rdy & avs_rdy & max_rdy), 32'd1);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
